alu_iter: RTL
=============

# alu_iter

Sequential execution unit directly downstream of the ALU control decoder in the single-cycle datapath. It consumes the 4-bit ALU operation code plus two WIDTH-bit operands. Logic, arithmetic and compare operations complete in one cycle. Shifts run iteratively, one bit position per cycle, under a start/busy/done handshake, so the datapath needs no barrel shifter.

## Interface
- WIDTH, 32, operand/result width; must be a power of two ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- aluopr_i  input  4  operation code from ALU control
- a_i  input  WIDTH  operand A, shift source
- b_i  input  WIDTH  operand B; b_i[SHW-1:0] is the shift amount
- busy_o  output  1  high while a shift is iterating
- done_o  output  1  one-cycle pulse: result_o/zero_o/err_o valid
- result_o  output  WIDTH  registered result, held until next completion
- zero_o  output  1  registered (result_o == 0)
- err_o  output  1  registered; 1 when the completed code was invalid

## Operation
- Codes: 0000 ADD, 0100 SUB, 0001 AND, 0010 OR, 0011 XOR, 0101 SLT (signed), 0110 SLTU, 1001 SLL, 1010 SRL, 1011 SRA. Every other code is invalid; this includes 1111, the decoder's default.
- Arithmetic is modulo 2^WIDTH with no carry or overflow output. SLT and SLTU return 1 or 0, zero-extended to WIDTH.
- Invalid code: result_o = 0, zero_o = 1, err_o = 1, with single-cycle latency. Valid completion: err_o = 0.
- States: IDLE and SHIFT.
- IDLE, start_i = 1, non-shift code: result computed combinationally and registered; done_o = 1 next cycle; remains in IDLE.
- IDLE, start_i = 1, shift code, N = b_i[SHW-1:0]:
  - N = 0: result = a_i, done next cycle, like a non-shift code.
  - N ≥ 1: load accumulator with a_i, counter with N, latch the shift kind, go to SHIFT.
- SHIFT, each cycle:
  - Shift the accumulator one position. SLL fills 0, SRL fills 0, SRA fills the sign bit, which stays the accumulator MSB.
  - Decrement the counter.
  - On the edge where the counter equals 1: write the shifted value to result_o, pulse done_o, return to IDLE.
- start_i while in SHIFT is ignored, not queued. a_i, b_i and aluopr_i may change freely after the start cycle.
- result_o, zero_o and err_o change only on a completion edge. During SHIFT they hold the previous completion's values.
- b_i bits above SHW-1 are ignored for shifts.

## Timing
- Reset: state = IDLE, result_o = 0, zero_o = 1, err_o = 0, done_o = 0, busy_o = 0; accumulator and counter cleared.
- Reset in SHIFT aborts the shift: no done_o pulse; outputs take reset values the next cycle.
- Reset has priority over start_i on the same edge.
- Latency, start cycle to done_o cycle: 1 for non-shift, invalid and N = 0 codes; N + 1 for a shift by N ≥ 1.
  - Maximum latency is WIDTH cycles (N = WIDTH-1).
- busy_o = (state == SHIFT), registered.
  - Shift by N ≥ 1: busy_o high for exactly N cycles, deasserting in the cycle done_o rises.
  - busy_o is never high for a single-cycle op.
- done_o is high for exactly one cycle per accepted start.
- A new start_i is accepted in the cycle done_o is high, since the unit is then in IDLE. Back-to-back single-cycle ops give one result per cycle.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit operation code localparams (the same constants the ALU control decoder uses);
  - the state enum {IDLE, SHIFT};
  - helper is_shift(op).
- Sub-module alu_core: purely combinational ADD/SUB/AND/OR/XOR/SLT/SLTU plus the invalid-code flag. alu_iter instantiates it and owns all sequential logic (FSM, accumulator, counter, output registers).

## Test plan
- Reset with start_i held high, then released: outputs at reset values, no done_o pulse; the first start after release is accepted.
- ADD 0x7FFF_FFFF + 1 → result 0x8000_0000, done_o one cycle later. SUB 5 − 5 → result 0, zero_o = 1. SLT 0xFFFF_FFFF vs 1 → result 1. SLTU of the same operands → result 0.
- SRA a = 0x8000_0000, b = 4 → done after 5 cycles, busy_o high 4 cycles, result 0xF800_0000. SRL of the same operands → 0x0800_0000. SLL a = 1, b = 31 → 0x8000_0000 at latency 32.
- Shift with b = 0x0000_0020 (N = 0) → result = a_i at latency 1, busy_o never high. start_i pulsed during a shift by 10 → ignored, exactly one done_o.
- aluopr_i = 1111 → result 0, zero_o = 1, err_o = 1 at latency 1. A following valid ADD clears err_o.
- rst_i asserted in the third SHIFT cycle of a shift by 8 → no done_o; result_o = 0 and state IDLE the next cycle. A subsequent XOR 0xF0F0 ^ 0x0FF0 → 0xFF00.

Source files
------------

// File: rtl/alu_pkg.sv
//==============================================================================
// alu_pkg : operation codes, FSM state type and helpers shared by the ALU blocks
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
//==============================================================================
// alu_core : single-cycle logic/arithmetic/compare datapath with invalid flag
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             invalid_o
);

  always_comb begin
    result_o  = '0;
    invalid_o = 1'b0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      // Shift codes are legal but produced by the iterative path in alu_iter.
      OP_SLL, OP_SRL, OP_SRA: result_o = '0;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_iter.sv
//==============================================================================
// alu_iter : execution unit with one-cycle ALU ops and bit-serial shifts
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       aluopr_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       kind_q, kind_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] core_result;
  logic             core_invalid;
  logic [WIDTH-1:0] acc_shifted;
  logic [SHW-1:0]   shamt;

  assign shamt = b_i[SHW-1:0];

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i      (aluopr_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .result_o  (core_result),
    .invalid_o (core_invalid)
  );

  always_comb begin
    case (kind_q)
      OP_SLL:  acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
      OP_SRA:  acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_shifted = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (is_shift(aluopr_i) && (shamt != '0)) begin
            acc_d   = a_i;
            cnt_d   = shamt;
            kind_d  = aluopr_i;
            state_d = SHIFT;
          end else if (is_shift(aluopr_i)) begin
            result_d = a_i;
            zero_d   = (a_i == '0);
            err_d    = 1'b0;
            done_d   = 1'b1;
          end else begin
            result_d = core_invalid ? '0 : core_result;
            zero_d   = core_invalid ? 1'b1 : (core_result == '0);
            err_d    = core_invalid;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - 1'b1;
        // The last iteration commits straight from the shifter output.
        if (cnt_q == SHW'(1)) begin
          result_d = acc_shifted;
          zero_d   = (acc_shifted == '0);
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      kind_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign err_o    = err_q;

endmodule

`default_nettype wire
